// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative RV32M multiply/divide unit with a fixed 33-cycle
//               latency (shift-add multiply, restoring divide).
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] c_mul    = 3'b000;
    localparam logic [2:0] c_mulh   = 3'b001;
    localparam logic [2:0] c_mulhsu = 3'b010;
    localparam logic [2:0] c_mulhu  = 3'b011;
    localparam logic [2:0] c_div    = 3'b100;
    localparam logic [2:0] c_divu   = 3'b101;
    localparam logic [2:0] c_rem    = 3'b110;
    localparam logic [2:0] c_remu   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_funct3;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_div_zero;
    logic              r_overflow;
    logic [XLEN-1:0]   r_mag_a;
    logic [XLEN-1:0]   r_mag_b;
    logic [XLEN-1:0]   r_opa;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;

    // Operand decode at accept time
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;

    assign w_a_signed = (i_funct3 != c_mulhu) && (i_funct3 != c_divu) && (i_funct3 != c_remu);
    assign w_b_signed = (i_funct3 == c_mul) || (i_funct3 == c_mulh) ||
                        (i_funct3 == c_div) || (i_funct3 == c_rem);
    assign w_neg_a    = w_a_signed & i_operand_a[XLEN-1];
    assign w_neg_b    = w_b_signed & i_operand_b[XLEN-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_mag_a    = w_neg_a ? (-i_operand_a) : i_operand_a;
    assign w_mag_b    = w_neg_b ? (-i_operand_b) : i_operand_b;

    // Multiply step: accumulator holds {partial product high, remaining multiplier}
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: accumulator holds {remainder, dividend bits / quotient bits}
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_next;

    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
    assign w_div_rem   = w_div_ge ? (w_div_shift[XLEN-1:0] - r_mag_b) : w_div_shift[XLEN-1:0];
    assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

    // Sign correction and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign w_prod = (r_sign_a ^ r_sign_b) ? (-r_acc) : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    assign w_rem  = r_sign_a ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_result = '0;
        case (r_funct3)
            c_mul:                     w_result = w_prod[XLEN-1:0];
            c_mulh, c_mulhsu, c_mulhu: w_result = w_prod[2*XLEN-1:XLEN];
            c_div, c_divu: begin
                if (r_div_zero)      w_result = '1;
                else if (r_overflow) w_result = {1'b1, {(XLEN-1){1'b0}}};
                else                 w_result = w_quo;
            end
            c_rem, c_remu: begin
                if (r_div_zero)      w_result = r_opa;
                else if (r_overflow) w_result = '0;
                else                 w_result = w_rem;
            end
            default:                   w_result = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_funct3   <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_opa      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_CALC;
                        r_funct3   <= i_funct3;
                        r_sign_a   <= w_neg_a;
                        r_sign_b   <= w_neg_b;
                        r_div_zero <= i_funct3[2] && (i_operand_b == '0);
                        r_overflow <= ((i_funct3 == c_div) || (i_funct3 == c_rem)) &&
                                      (i_operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                                      (i_operand_b == '1);
                        r_mag_a    <= w_mag_a;
                        r_mag_b    <= w_mag_b;
                        r_opa      <= i_operand_a;
                        r_acc      <= i_funct3[2] ? {{XLEN{1'b0}}, w_mag_a}
                                                  : {{XLEN{1'b0}}, w_mag_b};
                        r_cnt      <= '0;
                        o_busy     <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state  <= S_IDLE;
                    o_result <= w_result;
                    o_done   <= 1'b1;
                    o_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md_unit #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_funct3    (funct3),
        .i_operand_a (op_a),
        .i_operand_b (op_b),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; returns 1 time unit after E0.
    task automatic launch(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        funct3 = fn;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = ~fn;
        op_a   = ~a;
        op_b   = ~b;
    endtask

    // Counts edges until o_done is seen (bounded); also tracks busy before done.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   lat;
        logic busy_ok;
        launch(fn, a, b);
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        wait_done(lat, busy_ok);
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " result"}, result, exp);
        @(posedge clk);
        #1;
        check({tag, " done_pulse_width"}, 32'(done), 32'd0);
        check({tag, " result_held"}, result, exp);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic done_seen;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_7_m3",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulh_m1_2",     3'b001, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF);
        run_op("mulhsu_ones",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_ones",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        run_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14);
        run_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2);
        run_op("divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF);
        run_op("remu_5_0",      3'b111, 32'd5,        32'd0,        32'd5);
        run_op("div_m7_0",      3'b100, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF);
        run_op("rem_m7_0",      3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9);
        run_op("div_overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Second start while busy must be ignored
        launch(3'b000, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, busy_ok);
        check("ignore latency_from_e10", 32'(lat), 32'd23);
        check("ignore result", result, 32'd42);

        // Start during the done cycle is accepted back-to-back
        launch(3'b000, 32'd5, 32'd9);
        wait_done(lat, busy_ok);
        check("b2b first latency", 32'(lat), 32'd33);
        check("b2b first result", result, 32'd45);
        launch(3'b101, 32'd100, 32'd7);
        check("b2b second accepted", 32'(busy), 32'd1);
        wait_done(lat, busy_ok);
        check("b2b second latency", 32'(lat + 1), 32'd34);
        check("b2b second result", result, 32'd14);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-calculation
        launch(3'b000, 32'h0000_1234, 32'h10);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check("midreset no_done", 32'(done_seen), 32'd0);
        run_op("mul_3_4_after_reset", 3'b000, 32'd3, 32'd4, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative RV32M multiply/divide unit; sits downstream of the operand-B select stage, in parallel with the ALU.
- Consumes i_operand_a and i_operand_b and returns one 32-bit result after a fixed 33-cycle latency.
- The control unit stalls the PC while o_busy is high and writes o_result back on o_done.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  request; accepted only in IDLE.
- i_funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_operand_a  input  XLEN  rs1 value (multiplicand / dividend).
- i_operand_b  input  XLEN  output of operand-B select (multiplier / divisor).
- o_busy  output  1  high from accept until result is registered.
- o_done  output  1  one-cycle pulse; o_result is valid in this cycle.
- o_result  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE.
  - o_busy=0, o_done=0, o_result=0.
  - All internal registers cleared.
  - Applies at any time, including mid-operation; the operation is discarded and no o_done is produced.
- FSM states: IDLE, CALC, FIN.
  - IDLE -> CALC on edge E0 with i_start=1. Latch funct3, sign flags, operand magnitudes, and special-case flags. Clear the iteration counter. Set o_busy=1.
  - CALC: one iteration per edge. 32 iterations on E1..E32; 5-bit counter; leave CALC when counter==31.
    - Multiply: shift-add on magnitudes into a 64-bit accumulator.
    - Divide: restoring shift-subtract; 32-bit quotient and remainder.
  - FIN -> IDLE on E33:
    - Apply sign correction and special cases.
    - Register o_result.
    - o_done=1 for the cycle after E33.
    - o_busy=0 after E33.
  - Fixed latency: start sampled at E0 -> o_done high during cycle E33..E34. No early-out.
- Handshake:
  - i_start is ignored while o_busy=1.
  - o_done clears on the next edge.
  - A start asserted during the o_done cycle is accepted at E34 (back-to-back).
  - Operand/funct3 changes after E0 have no effect.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Signed operands are converted to magnitudes. The product is negated if the sign flags differ.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- Result select:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Divide by zero (b==0):
  - Quotient = 0xFFFFFFFF, signed and unsigned.
  - Remainder = a (unmodified).
  - Still takes the full 33 cycles.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
  - Quotient = 0x80000000, remainder = 0.
- Magnitude of 0x80000000: 33-bit internal path or unsigned interpretation; it must not wrap to a negative magnitude.
- Arithmetic: all intermediate values are unsigned and at least 64 bits (multiply) / 33 bits (divide subtract). No X propagation into o_result.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), start at E0 -> o_busy=1 E0..E33, o_done pulse after E33 only, o_result=0xFFFFFFEB.
- MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF. REMU -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same -> 0. All with 33-cycle latency.
- Busy rules: second i_start pulsed at E10 with different operands -> ignored, first result unchanged. Start asserted in the o_done cycle -> accepted, second o_done 34 cycles later.
- Async reset asserted mid-CALC (between E10 and E11) -> o_busy=0, o_done=0, o_result=0 immediately. No o_done afterwards. A fresh MUL 3*4 after release -> 12.
